// File: rtl/exec_pkg.sv
// Shared types and helpers for the Tomasulo execution units.
// Op/state encodings and the per-op latency lookup.
package exec_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } fu_state_e;

  function automatic int unsigned op_latency(input fu_op_e op,
                                             input int unsigned add_lat,
                                             input int unsigned mul_lat,
                                             input int unsigned div_lat);
    int unsigned lat;
    case (op)
      OP_MUL:  lat = mul_lat;
      OP_DIV:  lat = div_lat;
      default: lat = add_lat;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/tomasulo_fu_iter_rs_select.sv
// Lowest-index priority picker over the reservation-station ready vector.
// Returns a one-hot grant and whether any entry is ready.
module rs_select #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant,
  output logic         any_ready
);

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ready[i] && (grant == '0)) grant[i] = 1'b1;
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/tomasulo_fu_iter.sv
// Generic iterative functional unit: picks a ready RS entry, runs ADD/SUB/MUL/DIV
// for a per-op latency and presents the result on the CDB with valid/ready.
module tomasulo_fu_iter
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned RS_ENTRIES = 3,
  parameter int unsigned ADD_LAT    = 2,
  parameter int unsigned MUL_LAT    = 10,
  parameter int unsigned DIV_LAT    = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [RS_ENTRIES-1:0]       rs_ready,
  input  logic [2*RS_ENTRIES-1:0]     rs_op,
  input  logic [XLEN*RS_ENTRIES-1:0]  rs_src1,
  input  logic [XLEN*RS_ENTRIES-1:0]  rs_src2,
  input  logic [TAG_W*RS_ENTRIES-1:0] rs_tag,
  output logic [RS_ENTRIES-1:0]       rs_grant,
  output logic                        busy,
  output logic                        cdb_valid,
  input  logic                        cdb_ready,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [XLEN-1:0]             cdb_value,
  output logic                        cdb_exc
);

  localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int unsigned MAX_LAT = (MAX_AM > DIV_LAT) ? MAX_AM : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_lat_check
    $error("tomasulo_fu_iter: every latency must be at least 1");
  end

  fu_state_e         state;
  logic [CNT_W-1:0]  cnt;
  fu_op_e            op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [TAG_W-1:0]  tag_q;

  logic [RS_ENTRIES-1:0] sel_grant;
  logic                  any_ready;
  logic [1:0]            sel_op;
  logic [XLEN-1:0]       sel_a;
  logic [XLEN-1:0]       sel_b;
  logic [TAG_W-1:0]      sel_tag;
  logic                  dispatch;
  logic [XLEN-1:0]       res_val;
  logic                  res_exc;

  rs_select #(.N(RS_ENTRIES)) u_rs_select (
    .ready     (rs_ready),
    .grant     (sel_grant),
    .any_ready (any_ready)
  );

  always_comb begin
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int unsigned i = 0; i < RS_ENTRIES; i++) begin
      if (sel_grant[i]) begin
        sel_op  = sel_op  | rs_op[2*i +: 2];
        sel_a   = sel_a   | rs_src1[XLEN*i +: XLEN];
        sel_b   = sel_b   | rs_src2[XLEN*i +: XLEN];
        sel_tag = sel_tag | rs_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign dispatch = ((state == ST_IDLE) || (state == ST_DONE && cdb_ready))
                    && any_ready && !flush;

  always_comb begin
    res_val = '0;
    res_exc = 1'b0;
    case (op_q)
      OP_ADD: res_val = a_q + b_q;
      OP_SUB: res_val = a_q - b_q;
      OP_MUL: res_val = a_q * b_q;
      OP_DIV: begin
        if (b_q == '0) begin
          res_val = '1;
          res_exc = 1'b1;
        end else begin
          res_val = a_q / b_q;
        end
      end
      default: ;
    endcase
  end

  // Dispatch is only possible from IDLE or an accepted DONE, so it is taken
  // ahead of the per-state handling rather than duplicated in both states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      rs_grant  <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_exc   <= 1'b0;
    end else begin
      rs_grant <= dispatch ? sel_grant : '0;
      if (flush) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (dispatch) begin
        op_q  <= fu_op_e'(sel_op);
        a_q   <= sel_a;
        b_q   <= sel_b;
        tag_q <= sel_tag;
        cnt   <= CNT_W'(op_latency(fu_op_e'(sel_op), ADD_LAT, MUL_LAT, DIV_LAT) - 1);
        state <= ST_EXEC;
      end else begin
        case (state)
          ST_EXEC: begin
            if (cnt == '0) begin
              cdb_tag   <= tag_q;
              cdb_value <= res_val;
              cdb_exc   <= res_exc;
              state     <= ST_DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          ST_DONE: if (cdb_ready) state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign cdb_valid = (state == ST_DONE);

endmodule

// File: tb/tb_tomasulo_fu_iter.sv
// Self-checking bench for tomasulo_fu_iter: scoreboard of expected CDB results
// plus per-scenario latency, grant, backpressure, flush and reset checks.
module tb_tomasulo_fu_iter;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned NE      = 3;
  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned MUL_LAT = 10;
  localparam int unsigned DIV_LAT = 40;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
    logic             exc;
  } res_t;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [NE-1:0]         rs_ready;
  logic [2*NE-1:0]       rs_op;
  logic [XLEN*NE-1:0]    rs_src1;
  logic [XLEN*NE-1:0]    rs_src2;
  logic [TAG_W*NE-1:0]   rs_tag;
  logic [NE-1:0]         rs_grant;
  logic                  busy;
  logic                  cdb_valid;
  logic                  cdb_ready;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_value;
  logic                  cdb_exc;

  int   n_cmp;
  int   n_err;
  res_t sb_q[$];

  tomasulo_fu_iter #(
    .XLEN(XLEN), .TAG_W(TAG_W), .RS_ENTRIES(NE),
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rs_ready(rs_ready), .rs_op(rs_op), .rs_src1(rs_src1), .rs_src2(rs_src2),
    .rs_tag(rs_tag), .rs_grant(rs_grant), .busy(busy),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_exc(cdb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted CDB transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && cdb_valid && cdb_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL cdb_unexpected: got tag=%0d value=%h exc=%0b, required no transfer",
                 cdb_tag, cdb_value, cdb_exc);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        if ({cdb_tag, cdb_value, cdb_exc} !== e) begin
          n_err++;
          $display("FAIL cdb_result: got tag=%0d value=%h exc=%0b, required tag=%0d value=%h exc=%0b",
                   cdb_tag, cdb_value, cdb_exc, e.tag, e.val, e.exc);
        end
      end
    end
  end

  function automatic logic [XLEN-1:0] model_val(input logic [1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    case (op)
      2'b00: return a + b;
      2'b01: return a - b;
      2'b10: begin p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; return p[XLEN-1:0]; end
      default: return (b == 0) ? {XLEN{1'b1}} : a / b;
    endcase
  endfunction

  task automatic set_entry(input int idx, input logic [1:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    rs_op[2*idx +: 2]          = op;
    rs_src1[XLEN*idx +: XLEN]  = a;
    rs_src2[XLEN*idx +: XLEN]  = b;
    rs_tag[TAG_W*idx +: TAG_W] = tag;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rs_grant, busy, cdb_valid, cdb_tag, cdb_value, cdb_exc} !== '0) begin
      n_err++;
      $display("FAIL reset_in: got grant=%b busy=%b valid=%b tag=%0d value=%h exc=%b, required all 0",
               rs_grant, busy, cdb_valid, cdb_tag, cdb_value, cdb_exc);
    end
    #7 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({rs_grant, busy, cdb_valid, cdb_tag, cdb_value, cdb_exc} !== '0) begin
      n_err++;
      $display("FAIL reset_out: got grant=%b busy=%b valid=%b, required all 0",
               rs_grant, busy, cdb_valid);
    end
  endtask

  task automatic run_single(input string name, input logic [1:0] op,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] exp_val,
                            input logic exp_exc, input int unsigned exp_lat);
    int unsigned lat;
    bit seen;
    bit extra_grant;
    sb_q.push_back('{tag: tag, val: exp_val, exc: exp_exc});
    set_entry(0, op, a, b, tag);
    cdb_ready = 1'b1;
    rs_ready  = 3'b001;
    @(posedge clk); #1;
    rs_ready = '0;
    set_entry(0, 2'b00, $urandom, $urandom, 4'hF);
    n_cmp++;
    if (rs_grant !== 3'b001) begin
      n_err++;
      $display("FAIL %s_grant: got %b, required 001", name, rs_grant);
    end
    lat = 0; seen = 0; extra_grant = 0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (rs_grant !== '0) extra_grant = 1;
      if (cdb_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || lat != exp_lat || extra_grant) begin
      n_err++;
      $display("FAIL %s_latency: got seen=%0b lat=%0d extra_grant=%0b, required lat=%0d",
               name, seen, lat, extra_grant, exp_lat);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle: got busy=%b valid=%b, required 0 0", name, busy, cdb_valid);
    end
  endtask

  task automatic test_arith();
    run_single("add",    2'b00, 32'd5,       32'd7,       4'd3, 32'h0000000C, 1'b0, ADD_LAT);
    run_single("sub",    2'b01, 32'd3,       32'd5,       4'd4, 32'hFFFFFFFE, 1'b0, ADD_LAT);
    run_single("mul",    2'b10, 32'h10000,   32'h10000,   4'd5, 32'h00000000, 1'b0, MUL_LAT);
    run_single("div0",   2'b11, 32'd100,     32'd0,       4'd6, 32'hFFFFFFFF, 1'b1, DIV_LAT);
    run_single("div7",   2'b11, 32'd100,     32'd7,       4'd7, 32'd14,       1'b0, DIV_LAT);
    run_single("mulbig", 2'b10, 32'h12345678, 32'h9ABCDEF0, 4'd8, 32'h242D2080, 1'b0, MUL_LAT);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [1:0]      op;
      logic [XLEN-1:0] a, b;
      int unsigned     lat;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (op == 2'b11) ? 32'($urandom_range(0, 300)) : $urandom;
      lat = (op == 2'b10) ? MUL_LAT : (op == 2'b11) ? DIV_LAT : ADD_LAT;
      run_single("rand", op, a, b, 4'(i), model_val(op, a, b),
                 (op == 2'b11 && b == 0), lat);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned lat;
    bit seen;
    sb_q.push_back('{tag: 4'd1, val: 32'd3, exc: 1'b0});
    sb_q.push_back('{tag: 4'd2, val: 32'd6, exc: 1'b0});
    set_entry(0, 2'b00, 32'd1,  32'd2, 4'd1);
    set_entry(2, 2'b01, 32'd10, 32'd4, 4'd2);
    cdb_ready = 1'b0;
    rs_ready  = 3'b101;
    @(posedge clk); #1;
    rs_ready = 3'b100;
    n_cmp++;
    if (rs_grant !== 3'b001) begin
      n_err++;
      $display("FAIL prio_grant: got %b, required 001", rs_grant);
    end
    seen = 0; lat = 0;
    while (!seen && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (cdb_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || lat != ADD_LAT) begin
      n_err++;
      $display("FAIL prio_latency: got seen=%0b lat=%0d, required lat=%0d", seen, lat, ADD_LAT);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (cdb_valid !== 1'b1 || cdb_tag !== 4'd1 || cdb_value !== 32'd3 ||
          cdb_exc !== 1'b0 || rs_grant !== '0) begin
        n_err++;
        $display("FAIL hold_%0d: got valid=%b tag=%0d value=%h exc=%b grant=%b, required 1 1 3 0 000",
                 c, cdb_valid, cdb_tag, cdb_value, cdb_exc, rs_grant);
      end
    end
    cdb_ready = 1'b1;
    @(posedge clk); #1;
    rs_ready = '0;
    n_cmp++;
    if (rs_grant !== 3'b100 || busy !== 1'b1 || cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_grant: got grant=%b busy=%b valid=%b, required 100 1 0",
               rs_grant, busy, cdb_valid);
    end
    seen = 0; lat = 0;
    while (!seen && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (cdb_valid) seen = 1;
    end
    n_cmp++;
    if (!seen || lat != ADD_LAT) begin
      n_err++;
      $display("FAIL b2b_latency: got seen=%0b lat=%0d, required lat=%0d", seen, lat, ADD_LAT);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_flush();
    bit saw_valid;
    set_entry(0, 2'b10, 32'h10000, 32'h10000, 4'd5);
    cdb_ready = 1'b1;
    rs_ready  = 3'b001;
    @(posedge clk); #1;
    rs_ready = '0;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle: got busy=%b valid=%b, required 0 0", busy, cdb_valid);
    end
    saw_valid = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (cdb_valid) saw_valid = 1;
    end
    n_cmp++;
    if (saw_valid) begin
      n_err++;
      $display("FAIL flush_no_cdb: got cdb_valid=1 after flush, required 0");
    end
    flush    = 1'b1;
    rs_ready = 3'b001;
    @(posedge clk); #1;
    flush    = 1'b0;
    rs_ready = '0;
    n_cmp++;
    if (rs_grant !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_grant: got grant=%b busy=%b, required 000 0", rs_grant, busy);
    end
  endtask

  task automatic test_reset_mid();
    set_entry(0, 2'b11, 32'd100, 32'd3, 4'd9);
    cdb_ready = 1'b1;
    rs_ready  = 3'b001;
    @(posedge clk); #1;
    rs_ready = '0;
    repeat (19) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rs_grant, busy, cdb_valid, cdb_tag, cdb_value, cdb_exc} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got grant=%b busy=%b valid=%b tag=%0d value=%h exc=%b, required all 0",
               rs_grant, busy, cdb_valid, cdb_tag, cdb_value, cdb_exc);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0 || cdb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b valid=%b, required 0 0", busy, cdb_valid);
    end
    run_single("post_rst", 2'b00, 32'd20, 32'd22, 4'd6, 32'd42, 1'b0, ADD_LAT);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rs_ready  = '0;
    rs_op     = '0;
    rs_src1   = '0;
    rs_src2   = '0;
    rs_tag    = '0;
    cdb_ready = 1'b0;
    #16;
    test_reset();
    test_arith();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d results outstanding, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
